// File: rtl/wb_stage_param.sv
// wb_stage_param: parametrised LoongArch write-back stage driving the RF byte-write port,
// the decode forwarding bus and a retire counter. Define WB_TRACE_FIFO_EN to buffer the debug trace.
module wb_stage_param #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned RF_ADDR_W   = 5,
    parameter int unsigned TRACE_DEPTH = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned BUS_W       = PC_W + XLEN/8 + RF_ADDR_W + XLEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ms_valid,
    output logic                 ws_allowin,
    input  logic [BUS_W-1:0]     ms_to_ws_bus,
    output logic [XLEN/8-1:0]    rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 ws_fwd_valid,
    output logic [RF_ADDR_W-1:0] ws_fwd_dest,
    output logic [XLEN-1:0]      ws_fwd_data,
    output logic [CNT_W-1:0]     retire_cnt,
    output logic                 debug_wb_valid,
    input  logic                 debug_wb_ready,
    output logic [PC_W-1:0]      debug_wb_pc,
    output logic [XLEN/8-1:0]    debug_wb_rf_we,
    output logic [RF_ADDR_W-1:0] debug_wb_rf_wnum,
    output logic [XLEN-1:0]      debug_wb_rf_wdata
);
    localparam int unsigned NB = XLEN / 8;

    logic                 ws_valid_q;
    logic [PC_W-1:0]      pc_q;
    logic [NB-1:0]        mask_q;
    logic [RF_ADDR_W-1:0] dest_q;
    logic [XLEN-1:0]      result_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 ws_ready_go;
    logic                 retire;
    logic [NB-1:0]        eff_mask;

    // r0 is hardwired zero: the write is dropped but the instruction still retires
    assign eff_mask   = (dest_q == '0) ? '0 : mask_q;
    assign ws_allowin = !ws_valid_q || ws_ready_go;
    assign retire     = ws_valid_q && ws_ready_go;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ws_valid_q <= 1'b0;
            pc_q       <= '0;
            mask_q     <= '0;
            dest_q     <= '0;
            result_q   <= '0;
        end else if (ws_allowin) begin
            ws_valid_q <= ms_valid;
            if (ms_valid) begin
                {pc_q, mask_q, dest_q, result_q} <= ms_to_ws_bus;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign retire_cnt   = cnt_q;
    assign rf_we        = retire ? eff_mask : '0;
    assign rf_waddr     = dest_q;
    assign rf_wdata     = result_q;
    assign ws_fwd_valid = ws_valid_q && (|eff_mask);
    assign ws_fwd_dest  = dest_q;
    assign ws_fwd_data  = result_q;

`ifdef WB_TRACE_FIFO_EN
    localparam int unsigned PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int unsigned ENT_W = PC_W + NB + RF_ADDR_W + XLEN;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(TRACE_DEPTH);

    logic [ENT_W-1:0] fifo_q [TRACE_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_C);
    assign pop         = !empty && debug_wb_ready;
    assign push        = retire;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign ws_ready_go = !full || pop;
    assign head        = empty ? '0 : fifo_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {pc_q, eff_mask, dest_q, result_q};
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PTR_W+1)'(1);
            end else if (!push && pop) begin
                count_q <= count_q - (PTR_W+1)'(1);
            end
        end
    end

    assign debug_wb_valid = !empty;
    assign {debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata} = head;
`else
    logic wb_unused;

    assign ws_ready_go       = 1'b1;
    assign wb_unused         = &{1'b0, debug_wb_ready, TRACE_DEPTH[0]};
    assign debug_wb_valid    = ws_valid_q;
    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_we    = ws_valid_q ? eff_mask : '0;
    assign debug_wb_rf_wnum  = dest_q;
    assign debug_wb_rf_wdata = result_q;
`endif

endmodule

// File: doc/wb_stage_param.md
# wb_stage_param

Parametrised write-back stage of the five-stage LoongArch pipeline, successor to the fixed-width WB unit. Accepts one retiring instruction per cycle from MEM over a valid/allowin handshake and drives the register-file write port with per-byte enables. Also drives the decode-stage forwarding bus and a retired-instruction counter. Debug trace output is either direct or buffered through a back-pressured trace FIFO, selected at compile time.

## Interface
- XLEN, 32: datapath width; multiple of 8.
- PC_W, 32: PC width.
- RF_ADDR_W, 5: register address width.
- TRACE_DEPTH, 4: trace FIFO entries; power of 2, ≥2; used only with the FIFO compiled in.
- CNT_W, 32: retire counter width.
- BUS_W, PC_W+XLEN/8+RF_ADDR_W+XLEN: MEM→WB bus width, derived.

- clk  in  1  clock
- reset  in  1  synchronous, active-low
- ms_valid  in  1  MEM holds a valid instruction
- ws_allowin  out  1  WB accepts a new instruction this cycle
- ms_to_ws_bus  in  BUS_W  {pc, we_mask[XLEN/8], dest, result}, MSB first
- rf_we  out  XLEN/8  register-file byte write enables
- rf_waddr  out  RF_ADDR_W  register-file write address
- rf_wdata  out  XLEN  register-file write data
- ws_fwd_valid  out  1  forwarding entry valid
- ws_fwd_dest  out  RF_ADDR_W  forwarding destination
- ws_fwd_data  out  XLEN  forwarding data
- retire_cnt  out  CNT_W  retired-instruction count
- debug_wb_valid  out  1  trace entry valid
- debug_wb_ready  in  1  trace consumer accepts the entry
- debug_wb_pc  out  PC_W  trace PC
- debug_wb_rf_we  out  XLEN/8  trace byte enables
- debug_wb_rf_wnum  out  RF_ADDR_W  trace register number
- debug_wb_rf_wdata  out  XLEN  trace data

## Operation
- Holding register: ws_valid plus the unpacked bus fields. Load when ms_valid && ws_allowin; ws_valid <= ms_valid whenever ws_allowin.
- ws_allowin = !ws_valid || ws_ready_go.
- Retire condition: ws_valid && ws_ready_go. Each retire:
  - Drives the RF write for that cycle.
  - Increments retire_cnt, mod 2^CNT_W.
  - Pushes one trace entry (FIFO build only).
- Effective mask: eff_mask = (dest==0) ? 0 : we_mask. Writes to r0 are suppressed, but the instruction still retires and is still counted and traced.
- RF port outputs:
  - rf_we = retire ? eff_mask : 0.
  - rf_waddr = dest; rf_wdata = result.
- Forwarding outputs:
  - ws_fwd_valid = ws_valid && |eff_mask. This is asserted even while stalled.
  - ws_fwd_dest = dest; ws_fwd_data = result.
- Trace entry contents: {pc, eff_mask, dest, result}.

## Timing
- Latency: bus captured at edge N; RF write, forwarding and trace are valid during cycle N+1 (direct build).
- Throughput: one instruction per cycle when not back-pressured.
- Reset (reset==0 at a posedge) clears:
  - ws_valid, all holding-register fields, retire_cnt and the FIFO pointers/count to 0.
  - All outputs to 0, except ws_allowin, which is 1.
- Reset asserted mid-operation drops the in-flight instruction and any buffered trace entries. It has priority over load and push.
- Unparked bus changes while ws_allowin==0 have no effect.

## Configuration
- Macro: WB_TRACE_FIFO_EN.
- Defined:
  - Trace passes through a TRACE_DEPTH-entry FIFO.
  - ws_ready_go = !full || pop, where pop = debug_wb_valid && debug_wb_ready. A push while full is legal only alongside a pop.
  - debug_wb_valid = !empty; debug_wb_* show the FIFO head.
  - A push into an empty FIFO becomes visible the next cycle, so trace latency is N+2.
  - Pointers wrap modulo TRACE_DEPTH.
- Undefined:
  - ws_ready_go = 1; debug_wb_ready is ignored.
  - debug_wb_valid = ws_valid.
  - debug_wb_pc/wnum/wdata = holding register.
  - debug_wb_rf_we = ws_valid ? eff_mask : 0.

## Test plan
- Reset: hold reset=0 for 3 cycles with ms_valid=1. Required: all outputs 0, ws_allowin=1, retire_cnt=0 one cycle after release.
- Streaming: ms_valid=1 for 8 cycles, pc=0x1c000000+4i, dest=i+1, we_mask=4'hF, result=i. Required: rf_we=4'hF for 8 consecutive cycles starting one cycle later, rf_waddr=1..8, retire_cnt=8.
- r0 write: dest=0, we_mask=4'hF, result=0xDEADBEEF. Required: rf_we=0 and ws_fwd_valid=0, but retire_cnt increments and the trace entry shows we=0.
- Partial write: we_mask=4'b0011, dest=5. Required: rf_we=4'b0011 and ws_fwd_valid=1 with ws_fwd_dest=5.
- FIFO back-pressure (macro defined, depth 4): debug_wb_ready=0 with 6 instructions offered. Required:
  - 5 accepted: 4 buffered plus 1 held in WB; ws_allowin drops to 0.
  - Raising debug_wb_ready drains the entries in order with PCs intact.
  - A full FIFO with a simultaneous pop and push keeps count at 4.
- Counter wrap (CNT_W=4): 17 retires -> retire_cnt=1.
